mem_responder: RTL and testbench

Memory-side responder for the processor's VMA/MD memory interface. It accepts one read or write request per start strobe, carrying the physical word address produced by the map from the selected VMA, and runs a fixed-wait access on an asynchronous SRAM-style bus. It returns read data into MD with a one-cycle finish pulse. It sits between the map/VMA/MD registers and main memory, opposite the VMA/map input selection path.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_wait_ctr.sv | 30 +++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the VMA/MD memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FINISH
  } mem_state_e;

  localparam int MEM_AW           = 22;
  localparam int MEM_WAIT_DEFAULT = 2;

endpackage

// File: rtl/mem_wait_ctr.sv
// 4-bit load/decrement wait counter with a zero flag.
module mem_wait_ctr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-wait SRAM access per memrq strobe,
// read data returned with a one-cycle mfinish pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT,
  parameter int AW          = MEM_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          memrq,
  input  logic          wrcyc,
  input  logic [AW-1:0] pma,
  input  logic [31:0]   md,
  output logic          busy,
  output logic          mfinish,
  output logic [31:0]   mem_rdata,
  output logic          overrun,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          sram_ce_n,
  output logic          sram_we_n
);

  mem_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wr_q, wr_d;
  logic          ovr_q, ovr_d;
  logic          ce_n_q, ce_n_d;
  logic          we_n_q, we_n_d;
  logic          ctr_load;
  logic          ctr_dec;
  logic          ctr_zero;

  mem_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    ovr_d    = ovr_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (memrq) begin
          state_d  = ACCESS;
          addr_d   = pma;
          wdata_d  = md;
          wr_d     = wrcyc;
          ctr_load = 1'b1;
        end
      end
      ACCESS: begin
        // A request during an access is dropped, only flagged.
        if (memrq) ovr_d = 1'b1;
        if (ctr_zero) begin
          state_d = FINISH;
          if (!wr_q) rdata_d = sram_rdata;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes follow the next state so they come straight from flops.
    ce_n_d = (state_d != ACCESS);
    we_n_d = !((state_d == ACCESS) && wr_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      ovr_q   <= ovr_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign busy       = (state_q == ACCESS);
  assign mfinish    = (state_q == FINISH);
  assign mem_rdata  = rdata_q;
  assign overrun    = ovr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with W=2 and W=0 instances.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memrq, wrcyc;
  logic [21:0] pma;
  logic [31:0] md, sram_rdata;
  logic        busy, mfinish, overrun, ce_n, we_n;
  logic [31:0] mem_rdata, wdata;
  logic [21:0] addr;

  logic        memrq0;
  logic [21:0] pma0;
  logic [31:0] sram_rdata0;
  logic        busy0, mfinish0, overrun0, ce_n0, we_n0;
  logic [31:0] mem_rdata0, wdata0;
  logic [21:0] addr0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2), .AW(22)) dut (
    .clk(clk), .reset_n(reset_n), .memrq(memrq), .wrcyc(wrcyc),
    .pma(pma), .md(md), .busy(busy), .mfinish(mfinish),
    .mem_rdata(mem_rdata), .overrun(overrun), .sram_addr(addr),
    .sram_wdata(wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(ce_n), .sram_we_n(we_n)
  );

  mem_responder #(.WAIT_CYCLES(0), .AW(22)) dut0 (
    .clk(clk), .reset_n(reset_n), .memrq(memrq0), .wrcyc(1'b0),
    .pma(pma0), .md(32'h0), .busy(busy0), .mfinish(mfinish0),
    .mem_rdata(mem_rdata0), .overrun(overrun0), .sram_addr(addr0),
    .sram_wdata(wdata0), .sram_rdata(sram_rdata0),
    .sram_ce_n(ce_n0), .sram_we_n(we_n0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    memrq = 1'b0; wrcyc = 1'b0; pma = '0; md = '0; sram_rdata = '0;
    memrq0 = 1'b0; pma0 = '0; sram_rdata0 = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mfinish", 32'(mfinish), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ce_n", 32'(ce_n), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst0_ce_n", 32'(ce_n0), 32'd1);
    chk("rst0_mfinish", 32'(mfinish0), 32'd0);

    // Read, W=2
    memrq = 1'b1; wrcyc = 1'b0; pma = 22'h001234;
    sram_rdata = 32'hDEADBEEF;
    tick();
    memrq = 1'b0;
    chk("rd_c1_ce_n", 32'(ce_n), 32'd0);
    chk("rd_c1_we_n", 32'(we_n), 32'd1);
    chk("rd_c1_busy", 32'(busy), 32'd1);
    chk("rd_addr", 32'(addr), 32'h001234);
    chk("rd_c1_mfinish", 32'(mfinish), 32'd0);
    tick();
    chk("rd_c2_ce_n", 32'(ce_n), 32'd0);
    tick();
    chk("rd_c3_ce_n", 32'(ce_n), 32'd0);
    chk("rd_c3_mfinish", 32'(mfinish), 32'd0);
    tick();
    chk("rd_fin_mfinish", 32'(mfinish), 32'd1);
    chk("rd_fin_ce_n", 32'(ce_n), 32'd1);
    chk("rd_fin_busy", 32'(busy), 32'd0);
    chk("rd_data", mem_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_idle_mfinish", 32'(mfinish), 32'd0);

    // Write, W=2
    memrq = 1'b1; wrcyc = 1'b1; pma = 22'h3FFFFF; md = 32'h0000A5A5;
    sram_rdata = 32'h12345678;
    tick();
    memrq = 1'b0; wrcyc = 1'b0;
    chk("wr_c1_ce_n", 32'(ce_n), 32'd0);
    chk("wr_c1_we_n", 32'(we_n), 32'd0);
    chk("wr_addr", 32'(addr), 32'h3FFFFF);
    chk("wr_wdata", wdata, 32'h0000A5A5);
    tick();
    chk("wr_c2_we_n", 32'(we_n), 32'd0);
    tick();
    chk("wr_c3_we_n", 32'(we_n), 32'd0);
    chk("wr_c3_ce_n", 32'(ce_n), 32'd0);
    tick();
    chk("wr_fin_mfinish", 32'(mfinish), 32'd1);
    chk("wr_fin_we_n", 32'(we_n), 32'd1);
    chk("wr_rdata_kept", mem_rdata, 32'hDEADBEEF);
    chk("wr_wdata_hold", wdata, 32'h0000A5A5);
    tick();

    // Overrun: second request during ACCESS is dropped
    memrq = 1'b1; wrcyc = 1'b0; pma = 22'h000055;
    sram_rdata = 32'h33333333;
    tick();
    memrq = 1'b0;
    chk("ovr_before", 32'(overrun), 32'd0);
    memrq = 1'b1; wrcyc = 1'b1; pma = 22'h000077;
    tick();
    memrq = 1'b0; wrcyc = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_addr_kept", 32'(addr), 32'h000055);
    chk("ovr_we_n", 32'(we_n), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    tick();
    chk("ovr_c3_mfinish", 32'(mfinish), 32'd0);
    tick();
    chk("ovr_fin_mfinish", 32'(mfinish), 32'd1);
    chk("ovr_rdata", mem_rdata, 32'h33333333);
    tick();
    tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_idle_addr", 32'(addr), 32'h000055);
    #2 reset_n = 1'b0;
    #1;
    chk("ovr_clr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // Back-to-back with memrq held high
    memrq = 1'b1; wrcyc = 1'b0; pma = 22'h000010;
    sram_rdata = 32'h11111111;
    tick();
    chk("b2b_a_ce_n", 32'(ce_n), 32'd0);
    tick();
    tick();
    chk("b2b_a_mf0", 32'(mfinish), 32'd0);
    tick();
    chk("b2b_a_mfinish", 32'(mfinish), 32'd1);
    chk("b2b_a_rdata", mem_rdata, 32'h11111111);
    pma = 22'h000020; sram_rdata = 32'h22222222;
    tick();
    memrq = 1'b0;
    chk("b2b_b_ce_n", 32'(ce_n), 32'd0);
    chk("b2b_b_addr", 32'(addr), 32'h000020);
    chk("b2b_b_mf0", 32'(mfinish), 32'd0);
    tick();
    chk("b2b_b_c2_mf", 32'(mfinish), 32'd0);
    tick();
    chk("b2b_b_c3_mf", 32'(mfinish), 32'd0);
    tick();
    chk("b2b_b_mfinish", 32'(mfinish), 32'd1);
    chk("b2b_b_rdata", mem_rdata, 32'h22222222);
    chk("b2b_overrun", 32'(overrun), 32'd1);
    tick();

    // Reset asserted mid-access
    memrq = 1'b1; pma = 22'h000099; sram_rdata = 32'h44444444;
    tick();
    memrq = 1'b0;
    tick();
    chk("mid_ce_n_pre", 32'(ce_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_ce_n", 32'(ce_n), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_overrun", 32'(overrun), 32'd0);
    chk("mid_addr", 32'(addr), 32'd0);
    chk("mid_rdata", mem_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_mfinish", 32'(mfinish), 32'd0);
    end
    reset_n = 1'b1;
    tick();
    chk("mid_after_mf", 32'(mfinish), 32'd0);
    chk("mid_after_busy", 32'(busy), 32'd0);

    // W=0 instance
    memrq0 = 1'b1; pma0 = 22'h000ABC; sram_rdata0 = 32'h5A5A5A5A;
    tick();
    memrq0 = 1'b0;
    chk("w0_ce_n", 32'(ce_n0), 32'd0);
    chk("w0_mf0", 32'(mfinish0), 32'd0);
    chk("w0_addr", 32'(addr0), 32'h000ABC);
    tick();
    chk("w0_mfinish", 32'(mfinish0), 32'd1);
    chk("w0_ce_n_fin", 32'(ce_n0), 32'd1);
    chk("w0_rdata", mem_rdata0, 32'h5A5A5A5A);
    tick();
    chk("w0_idle_mf", 32'(mfinish0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
